loctag_ui_ctrl: RTL and testbench

//  Parametrised user-interface front-end for the loctag tag top level. Replaces direct key-to-mode

---
 rtl/loctag_ui_ctrl_pkg.sv | 22 ++
 rtl/loctag_key_debounce.sv | 54 +++++
 rtl/loctag_ui_ctrl.sv | 162 ++++++++++++++++
 tb/tb_loctag_ui_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/loctag_ui_ctrl_pkg.sv
// Shared types and helpers for the loctag user-interface front-end:
// LED blink FSM state encoding and a constant-time max helper for timer sizing.
package loctag_ui_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_IDLE = 2'd0,
    LED_ON   = 2'd1,
    LED_OFF  = 2'd2,
    LED_GAP  = 2'd3
  } led_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

endpackage

// File: rtl/loctag_key_debounce.sv
// One key: two-flop synchroniser followed by a counter debouncer that only
// accepts a new level after it has been stable for DEB_CYCLES-1 synced cycles.
module loctag_key_debounce #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic key_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FLIP = CNT_W'(DEB_CYCLES - 2);

  logic             meta_q;
  logic             sync_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Polarity is normalised ahead of the synchroniser so a reset value of 0 means released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= pin_i ^ ACTIVE_LOW;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  // The count reaches DEB_CYCLES-1 on the flipping cycle; any agreement clears it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_FLIP) begin
      deb_d = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign key_o = deb_q;

endmodule

// File: rtl/loctag_ui_ctrl.sv
// Key front-end for loctag: debounced keys drive force_fs and a mode word that is
// applied only while the core is idle; the LED blinks mode+1 times after each change.
module loctag_ui_ctrl #(
  parameter int NUM_KEYS   = 4,
  parameter int MODE_W     = 3,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DEB_CYCLES = 500000,
  parameter int BLINK_ON   = 5000000,
  parameter int BLINK_OFF  = 5000000,
  parameter int BLINK_GAP  = 20000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] pin_key,
  input  logic                core_busy,
  input  logic                led_in,
  output logic                force_fs,
  output logic [MODE_W-1:0]   mode,
  output logic                mode_change,
  output logic                pending,
  output logic                led
);

  import loctag_ui_ctrl_pkg::*;

  localparam int TMR_W = $clog2(max3(BLINK_ON, BLINK_OFF, BLINK_GAP) + 1);
  localparam int BLK_W = MODE_W + 1;
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(BLINK_ON - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(BLINK_OFF - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(BLINK_GAP - 1);

  logic [NUM_KEYS-1:0] deb_s;
  logic [MODE_W-1:0]   deb_mode_s;
  logic                pending_s;
  logic                apply_s;
  logic [MODE_W-1:0]   mode_q;
  logic [MODE_W-1:0]   mode_d;
  logic                force_q;
  logic                mode_change_q;
  logic                led_q;
  logic                led_d;
  logic                fsm_led_s;
  led_state_e          state_q;
  led_state_e          state_d;
  logic [TMR_W-1:0]    tmr_q;
  logic [TMR_W-1:0]    tmr_d;
  logic [BLK_W-1:0]    blinks_q;
  logic [BLK_W-1:0]    blinks_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    loctag_key_debounce #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .pin_i (pin_key[g]),
      .key_o (deb_s[g])
    );
  end

  assign deb_mode_s = deb_s[MODE_W:1];
  assign pending_s  = (deb_mode_s != mode_q) & ~reset;
  assign apply_s    = pending_s & ~core_busy;

  // Only the latest debounced mode is ever applied; there is no queue.
  always_comb begin
    mode_d = mode_q;
    if (apply_s) mode_d = deb_mode_s;
    else         mode_d = mode_q;
  end

  // Registered outputs plus LED FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= '0;
      force_q       <= 1'b0;
      mode_change_q <= 1'b0;
      led_q         <= 1'b0;
      state_q       <= LED_IDLE;
      tmr_q         <= '0;
      blinks_q      <= '0;
    end else begin
      mode_q        <= mode_d;
      force_q       <= deb_s[0];
      mode_change_q <= apply_s;
      led_q         <= led_d;
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      blinks_q      <= blinks_d;
    end
  end

  // LED decode; force_fs holds the LED on while the FSM keeps running.
  always_comb begin
    fsm_led_s = 1'b0;
    led_d     = 1'b0;
    case (state_q)
      LED_IDLE: fsm_led_s = led_in;
      LED_ON:   fsm_led_s = 1'b1;
      default:  fsm_led_s = 1'b0;
    endcase
    if (force_q) led_d = 1'b1;
    else         led_d = fsm_led_s;
  end

  // A mode change from any state restarts the blink code with the new count.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    blinks_d = blinks_q;
    if (mode_change_q) begin
      state_d  = LED_ON;
      tmr_d    = '0;
      blinks_d = {1'b0, mode_q} + BLK_ONE;
    end else begin
      case (state_q)
        LED_IDLE: begin
          tmr_d = '0;
        end
        LED_ON: begin
          if (tmr_q == ON_LAST) begin
            tmr_d    = '0;
            blinks_d = blinks_q - BLK_ONE;
            if (blinks_q == BLK_ONE) state_d = LED_GAP;
            else                     state_d = LED_OFF;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        LED_OFF: begin
          if (tmr_q == OFF_LAST) begin
            tmr_d   = '0;
            state_d = LED_ON;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        LED_GAP: begin
          if (tmr_q == GAP_LAST) begin
            tmr_d   = '0;
            state_d = LED_IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = LED_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  assign force_fs    = force_q;
  assign mode        = mode_q;
  assign mode_change = mode_change_q;
  assign pending     = pending_s;
  assign led         = led_q;

endmodule

// File: tb/tb_loctag_ui_ctrl.sv
// Directed bench for loctag_ui_ctrl with short debounce and blink timings.
module tb_loctag_ui_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pin_key;
  logic       core_busy;
  logic       led_in;
  logic       force_fs;
  logic [2:0] mode;
  logic       mode_change;
  logic       pending;
  logic       led;

  int checks = 0;
  int errors = 0;
  int mc_cnt = 0;

  typedef struct packed {
    logic [7:0] tid;
    logic [7:0] len;
    logic       busy;
    logic       exp_led;
  } run_t;

  run_t runs [17];

  loctag_ui_ctrl #(
    .NUM_KEYS   (4),
    .MODE_W     (3),
    .ACTIVE_LOW (1'b1),
    .DEB_CYCLES (8),
    .BLINK_ON   (4),
    .BLINK_OFF  (3),
    .BLINK_GAP  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pin_key     (pin_key),
    .core_busy   (core_busy),
    .led_in      (led_in),
    .force_fs    (force_fs),
    .mode        (mode),
    .mode_change (mode_change),
    .pending     (pending),
    .led         (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_change) mc_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_mc(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mode_change && n < max);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pin_key   = 4'hF;
    core_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic play(input int tid);
    int k;
    k = 0;
    for (int i = 0; i < 17; i++) begin
      if (int'(runs[i].tid) == tid) begin
        for (int j = 0; j < int'(runs[i].len); j++) begin
          core_busy = runs[i].busy;
          @(negedge clk);
          k++;
          check($sformatf("t%0d_led_k%0d", tid, k), {31'd0, led}, {31'd0, runs[i].exp_led});
        end
      end
    end
  endtask

  initial begin
    int n;
    int mc0;

    // {test id, cycles, core_busy, expected led}
    runs = '{
      '{8'd1, 8'd1,  1'b0, 1'b1}, '{8'd1, 8'd4,  1'b0, 1'b1}, '{8'd1, 8'd3,  1'b0, 1'b0},
      '{8'd1, 8'd4,  1'b0, 1'b1}, '{8'd1, 8'd10, 1'b0, 1'b0}, '{8'd1, 8'd4,  1'b0, 1'b1},
      '{8'd4, 8'd5,  1'b1, 1'b1}, '{8'd4, 8'd3,  1'b1, 1'b0}, '{8'd4, 8'd4,  1'b1, 1'b1},
      '{8'd4, 8'd3,  1'b1, 1'b0}, '{8'd4, 8'd6,  1'b0, 1'b1}, '{8'd4, 8'd3,  1'b0, 1'b0},
      '{8'd4, 8'd4,  1'b0, 1'b1}, '{8'd4, 8'd3,  1'b0, 1'b0}, '{8'd4, 8'd4,  1'b0, 1'b1},
      '{8'd4, 8'd10, 1'b0, 1'b0}, '{8'd4, 8'd4,  1'b0, 1'b1}
    };

    reset     = 1'b1;
    pin_key   = 4'hF;
    core_busy = 1'b0;
    led_in    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mode", {29'd0, mode}, 32'd0);
    check("rst_mc", {31'd0, mode_change}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_force", {31'd0, force_fs}, 32'd0);
    check("rst_led", {31'd0, led}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_mode", {29'd0, mode}, 32'd0);
    check("idle_led0", {31'd0, led}, 32'd0);

    // Test 1: key[1] press, 2-blink code then pass-through
    led_in = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_led1", {31'd0, led}, 32'd1);
    mc0 = mc_cnt;
    pin_key = 4'b1101;
    wait_mc(30, n);
    check("t1_latency", n, 32'd10);
    check("t1_mode", {29'd0, mode}, 32'd1);
    play(1);
    check("t1_mc_pulses", mc_cnt - mc0, 32'd1);

    // Test 2: short glitches on key[2] are rejected
    do_reset();
    mc0 = mc_cnt;
    repeat (3) begin
      pin_key = 4'b1011;
      repeat (5) @(negedge clk);
      pin_key = 4'b1111;
      repeat (5) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("t2_mode", {29'd0, mode}, 32'd0);
    check("t2_pending", {31'd0, pending}, 32'd0);
    check("t2_mc_pulses", mc_cnt - mc0, 32'd0);

    // Test 3: apply deferred by core_busy
    do_reset();
    core_busy = 1'b1;
    mc0 = mc_cnt;
    pin_key = 4'b0111;
    repeat (14) @(negedge clk);
    check("t3_pending_busy", {31'd0, pending}, 32'd1);
    check("t3_mode_busy", {29'd0, mode}, 32'd0);
    check("t3_mc_busy", mc_cnt - mc0, 32'd0);
    core_busy = 1'b0;
    @(negedge clk);
    check("t3_mode_apply", {29'd0, mode}, 32'd4);
    check("t3_mc_apply", {31'd0, mode_change}, 32'd1);
    check("t3_pending_clear", {31'd0, pending}, 32'd0);
    @(negedge clk);
    check("t3_mc_single", {31'd0, mode_change}, 32'd0);

    // Test 4: mode change during an ON phase restarts the code with 3 blinks
    do_reset();
    led_in = 1'b1;
    pin_key = 4'b1001;
    wait_mc(30, n);
    check("t4_latency", n, 32'd10);
    check("t4_mode3", {29'd0, mode}, 32'd3);
    pin_key = 4'b1011;
    play(4);
    check("t4_mode2", {29'd0, mode}, 32'd2);

    // Test 5: force_fs overrides the LED, then pass-through resumes
    do_reset();
    led_in = 1'b1;
    pin_key = 4'b1101;
    wait_mc(30, n);
    repeat (2) @(negedge clk);
    pin_key = 4'b1100;
    repeat (10) @(negedge clk);
    check("t5_force_on", {31'd0, force_fs}, 32'd1);
    for (int k = 13; k <= 24; k++) begin
      @(negedge clk);
      check($sformatf("t5_led_forced_k%0d", k), {31'd0, led}, 32'd1);
      if (k == 14) pin_key = 4'b1101;
    end
    @(negedge clk);
    check("t5_force_off", {31'd0, force_fs}, 32'd0);
    check("t5_led_resume1", {31'd0, led}, 32'd1);
    led_in = 1'b0;
    @(negedge clk);
    check("t5_led_resume0", {31'd0, led}, 32'd0);

    // Test 6: async reset during OFF with a pending mode, keys held through reset
    do_reset();
    led_in = 1'b0;
    pin_key = 4'b1001;
    wait_mc(30, n);
    core_busy = 1'b1;
    pin_key = 4'b1101;
    repeat (13) @(negedge clk);
    check("t6_pending_pre", {31'd0, pending}, 32'd1);
    check("t6_mode_pre", {29'd0, mode}, 32'd3);
    mc0 = mc_cnt;
    reset = 1'b1;
    #1;
    check("t6_rst_mode", {29'd0, mode}, 32'd0);
    check("t6_rst_mc", {31'd0, mode_change}, 32'd0);
    check("t6_rst_pending", {31'd0, pending}, 32'd0);
    check("t6_rst_force", {31'd0, force_fs}, 32'd0);
    check("t6_rst_led", {31'd0, led}, 32'd0);
    core_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("t6_no_mc_on_reset", mc_cnt - mc0, 32'd0);
    wait_mc(30, n);
    check("t6_latency", n, 32'd10);
    check("t6_mode", {29'd0, mode}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
